// File: rtl/mmio_result_port.sv
// Snoops CPU data-memory stores to RESULT_ADDR and queues them in a small FWFT FIFO for an external consumer.
// Latency: a captured word appears on out_valid/out_data one cycle after the store edge.
// Backpressure: out_ready stalls the drain; when full, stall gates the CPU PC and unpopped hits are dropped (sticky overflow).
module mmio_result_port #(
  parameter logic [31:0] RESULT_ADDR = 32'd16,
  parameter int          DEPTH       = 4,
  parameter int          PTR_W       = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [31:0]      addr,
  input  logic [31:0]      wd,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             stall,
  output logic             overflow,
  output logic [31:0]      last_value,
  output logic [7:0]       capture_total
);

  localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(DEPTH);

  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;
  logic [31:0]      r_last_value;
  logic [7:0]       r_capture_total;

  logic w_hit;
  logic w_full;
  logic w_valid;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Hit detection and handshake decode; full comes from registered count only,
  // so stall has no combinational path from the CPU bus.
  always_comb begin
    w_hit   = we && (addr == RESULT_ADDR);
    w_full  = (r_count == LP_DEPTH);
    w_valid = (r_count != '0);
    w_pop   = w_valid && out_ready;
    w_push  = w_hit && (!w_full || w_pop);
    w_drop  = w_hit && w_full && !w_pop;
  end

  // Storage write; contents are don't-care after reset, so no reset term.
  always_ff @(posedge clock) begin
    if (w_push && reset) begin
      r_mem[r_wr_ptr] <= wd;
    end
  end

  // Pointers and occupancy; reset wins over any simultaneous push or pop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Capture bookkeeping: last accepted word, saturating total, sticky drop flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_overflow      <= 1'b0;
      r_last_value    <= '0;
      r_capture_total <= '0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_push) begin
        r_last_value <= wd;
        if (r_capture_total != 8'hFF) r_capture_total <= r_capture_total + 8'd1;
      end
    end
  end

  // Output mapping; head word is combinational from storage and forced to 0 when empty.
  always_comb begin
    out_valid     = w_valid;
    out_data      = w_valid ? r_mem[r_rd_ptr] : 32'd0;
    count         = r_count;
    full          = w_full;
    stall         = w_full;
    overflow      = r_overflow;
    last_value    = r_last_value;
    capture_total = r_capture_total;
  end

endmodule

// File: tb/tb_mmio_result_port.sv
// Self-checking bench for mmio_result_port: directed scenarios plus random traffic vs a queue model.
// Inputs change 1ns after posedge; outputs are checked 1ns after posedge against the model.
// The model is a plain queue with overflow/last/total bookkeeping.
module tb_mmio_result_port;

  logic        clock;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [2:0]  count;
  logic        full;
  logic        stall;
  logic        overflow;
  logic [31:0] last_value;
  logic [7:0]  capture_total;

  mmio_result_port dut (
    .clock(clock), .reset(reset), .we(we), .addr(addr), .wd(wd),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .full(full), .stall(stall), .overflow(overflow),
    .last_value(last_value), .capture_total(capture_total)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_q[$];
  logic        m_ovf;
  logic [31:0] m_last;
  int          m_total;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by one edge, compare all outputs.
  task automatic cyc(input logic rst_n, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic rdy);
    logic pop;
    logic hit;
    reset = rst_n; we = w; addr = a; wd = d; out_ready = rdy;
    @(posedge clock);
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 1'b0; m_last = 32'd0; m_total = 0;
    end else begin
      pop = (m_q.size() > 0) && rdy;
      hit = w && (a == 32'd16);
      if (hit && (m_q.size() == 4) && !pop) begin
        m_ovf = 1'b1;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (hit) begin
          m_q.push_back(d);
          m_last = d;
          if (m_total < 255) m_total++;
        end
      end
    end
    #1;
    chk("count",     32'(count),         32'(m_q.size()));
    chk("out_valid", 32'(out_valid),     32'(m_q.size() > 0));
    chk("out_data",  out_data,           (m_q.size() > 0) ? m_q[0] : 32'd0);
    chk("full",      32'(full),          32'(m_q.size() == 4));
    chk("stall",     32'(stall),         32'(m_q.size() == 4));
    chk("overflow",  32'(overflow),      32'(m_ovf));
    chk("last",      last_value,         m_last);
    chk("total",     32'(capture_total), 32'(m_total));
  endtask

  initial begin
    logic [31:0] heads[$];
    m_ovf = 1'b0; m_last = 32'd0; m_total = 0;
    reset = 1'b0; we = 1'b0; addr = 32'd0; wd = 32'd0; out_ready = 1'b0;
    #1;

    // Reset then single capture
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 32'd16, 32'd2, 0);
    chk("single_data", out_data, 32'd2);
    chk("single_total", 32'(capture_total), 32'd1);
    cyc(1, 0, 0, 0, 1);  // drain

    // Address filter
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 32'd12, 32'd4, 0);
    cyc(1, 1, 32'd20, 32'd7, 0);
    cyc(1, 0, 32'd16, 32'd9, 0);
    cyc(1, 1, 32'h0001_0010, 32'd5, 0);
    chk("filter_count", 32'(count), 32'd0);

    // Fill and overflow
    for (int i = 0; i < 5; i++) cyc(1, 1, 32'd16, 32'(10 + i), 0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_last", last_value, 32'd13);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", out_data, 32'(10 + i));
      cyc(1, 0, 0, 0, 1);
    end
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full with simultaneous push/pop
    cyc(0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 1, 32'd16, 32'(i), 0);
    cyc(1, 1, 32'd16, 32'd99, 1);
    chk("pp_count", 32'(count), 32'd4);
    chk("pp_head", out_data, 32'd2);
    for (int i = 0; i < 4; i++) begin
      heads.push_back(out_data);
      cyc(1, 0, 0, 0, 1);
    end
    chk("pp_fourth", heads[3], 32'd99);
    chk("pp_no_ovf", 32'(overflow), 32'd0);

    // Pointer wrap
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 32'd16, 32'(100 + i), 0);
      chk("wrap_word", out_data, 32'(100 + i));
      cyc(1, 0, 0, 0, 1);
    end
    chk("wrap_empty", 32'(count), 32'd0);

    // Reset mid-operation with a hit presented
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'd16, 32'(50 + i), 0);
    cyc(0, 1, 32'd16, 32'd77, 1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_total", 32'(capture_total), 32'd0);

    // Saturation of capture_total with continuous push+pop
    cyc(1, 1, 32'd16, 32'd1, 0);
    for (int i = 0; i < 270; i++) cyc(1, 1, 32'd16, 32'(1000 + i), 1);
    chk("sat_total", 32'(capture_total), 32'd255);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      logic r_n;
      logic [31:0] a;
      r_n = ($urandom_range(0, 199) != 0);
      case ($urandom_range(0, 3))
        0: a = 32'd20;
        1: a = $urandom;
        default: a = 32'd16;
      endcase
      cyc(r_n, ($urandom_range(0, 3) != 0), a, $urandom, ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_result_port.md
Name: mmio_result_port

Overview:
- Memory-mapped output port downstream of the single-cycle CPU's data-memory write bus.
- Snoops the same write-enable, address and write-data signals that drive the data memory.
- Captures every store to a designated result address into a small FIFO and drains it to an external consumer (display/UART/testbench) over a valid/ready handshake.
- Provides a stall output so the CPU's PC enable can be gated while the FIFO is full.

Parameters:
- RESULT_ADDR, 32'd16: byte address whose stores are captured (the program's result slot).
- DEPTH, 4: FIFO entries; power of two, at least 2.
- PTR_W, 2: log2(DEPTH).

Ports:
- clock, input, 1: single clock; all state updates on posedge.
- reset, input, 1: synchronous, active-low; sampled on posedge clock.
- we, input, 1: CPU data-memory write enable.
- addr, input, 32: CPU data-memory address (ALU result).
- wd, input, 32: CPU data-memory write data.
- out_valid, output, 1: FIFO head word available.
- out_data, output, 32: FIFO head word; 0 when out_valid=0.
- out_ready, input, 1: consumer accepts the head word.
- count, output, PTR_W+1: current FIFO occupancy.
- full, output, 1: count==DEPTH.
- stall, output, 1: equals full; the CPU ANDs ~stall into PC enable.
- overflow, output, 1: sticky flag; a capture was dropped.
- last_value, output, 32: most recently accepted captured word.
- capture_total, output, 8: saturating count of accepted captures.

Behaviour:
- Reset (reset==0 at posedge):
  - Pointers, count, overflow, last_value and capture_total clear to 0.
  - Hence out_valid=0, out_data=0, full=0, stall=0 in the same cycle.
  - Reset overrides any simultaneous push or pop.
  - FIFO storage contents need not clear.
  - Reset mid-drain discards all entries.
- Hit: we==1 && addr==RESULT_ADDR. The full 32-bit compare is exact; no byte/half aliasing.
- Push (posedge):
  - Occurs when hit && (!full || pop).
  - Writes wd at wr_ptr; wr_ptr wraps modulo DEPTH.
  - last_value<=wd; capture_total increments, saturating at 255.
- Pop (posedge):
  - Occurs when out_valid && out_ready; rd_ptr wraps modulo DEPTH.
  - out_ready while empty has no effect.
- Latency and output timing:
  - A captured word is visible on out_valid/out_data the cycle after the push edge.
  - The FIFO is first-word-fall-through: out_data is combinational from storage[rd_ptr].
- count update:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
- Boundary cases:
  - Full with simultaneous pop: push accepted, count stays DEPTH.
  - Full without pop: hit dropped, overflow<=1 (sticky until reset), last_value and capture_total unchanged.
  - Empty: push and pop cannot coincide because out_valid=0.
- stall/full are registered-state derived (from count), so there is no combinational path from we/addr.
- The store itself still reaches the data memory. This block only observes and never drives the bus.
- Non-hit writes and reads (we==0) are ignored.
- Internal state: no FSM beyond FIFO pointers.
  - EMPTY: count==0.
  - PARTIAL: 0<count<DEPTH.
  - FULL: count==DEPTH.
  - Transitions follow the push/pop rules above.

Test Plan:
- Reset then single capture: reset low 2 cycles; we=1, addr=16, wd=32'd2 one cycle, out_ready=0 -> next cycle out_valid=1, out_data=2, count=1, last_value=2, capture_total=1.
- Address filter: we=1 with addr=12 (wd=4) and addr=20 (wd=7); we=0 with addr=16 -> count stays 0, out_valid=0, capture_total=0.
- Fill and overflow: 5 hits wd=10,11,12,13,14, out_ready=0 -> after 4th, full=1, stall=1, count=4; 5th dropped, overflow=1, last_value=13; drain gives 10,11,12,13 in order, then out_valid=0, overflow still 1.
- Full with simultaneous push/pop: fill with 1..4; in one cycle hit wd=99 with out_ready=1 -> count=4, next head=2, and 99 emerges as the 4th subsequent word.
- Pointer wrap: 10 push/pop pairs of wd=100..109, with each word drained before the next push -> every value received in order, count returns to 0, no overflow.
- Reset mid-operation: count=3, assert reset while a hit is presented -> next cycle count=0, out_valid=0, overflow=0, capture_total=0, and the hit is not captured.
